// File: rtl/latency_credit_buffer_pkg.sv
// Shared types and helpers for the latency credit buffer and its return FIFO.
package latency_credit_buffer_pkg;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  typedef enum logic [1:0] {
    CR_HOLD = 2'b00,
    CR_TAKE = 2'b01,
    CR_GIVE = 2'b10,
    CR_SWAP = 2'b11
  } credit_op_e;

  // Pointer increment that wraps at depth-1, so non-power-of-2 depths work.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
    logic [31:0] nxt_s;
    if (ptr == depth - 32'd1) begin
      nxt_s = 32'd0;
    end else begin
      nxt_s = ptr + 32'd1;
    end
    return nxt_s;
  endfunction

endpackage

// File: rtl/latency_credit_buffer_chk.sv
// Property checker: the credit counter must never be driven past either bound.
module latency_credit_buffer_chk #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst_n,
  input logic [AW:0] credit_cnt,
  input logic        fire,
  input logic        pop
);

  a_no_take_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
    fire |-> (credit_cnt != '0));

  a_no_give_at_full: assert property (@(posedge clk) disable iff (!rst_n)
    (pop && !fire) |-> (credit_cnt != (AW+1)'(DEPTH)));

  a_credit_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    credit_cnt <= (AW+1)'(DEPTH));

endmodule

// File: rtl/lcb_sync_fifo.sv
// Circular-buffer return FIFO; the occupancy counter alone decides full and empty.
module lcb_sync_fifo
  import latency_credit_buffer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int PW = (AW > 0) ? AW : 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [OW-1:0] occ_r;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  fifo_op_e      op_s;

  assign full_s  = (occ_r == OW'(DEPTH));
  assign empty_s = (occ_r == '0);
  assign full    = full_s;
  assign empty   = empty_s;
  assign rd_data = mem_r[rd_ptr_r];

  // A write into a full FIFO only lands when the same cycle frees a slot.
  always_comb begin
    pop_s  = rd_en & ~empty_s;
    push_s = wr_en & (~full_s | pop_s);
    op_s   = fifo_op_e'({pop_s, push_s});
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
    end else begin
      case (op_s)
        FIFO_PUSH: begin
          wr_ptr_r <= PW'(wrap_inc(32'(wr_ptr_r), 32'(DEPTH)));
          occ_r    <= occ_r + OW'(1);
        end
        FIFO_POP: begin
          rd_ptr_r <= PW'(wrap_inc(32'(rd_ptr_r), 32'(DEPTH)));
          occ_r    <= occ_r - OW'(1);
        end
        FIFO_BOTH: begin
          wr_ptr_r <= PW'(wrap_inc(32'(wr_ptr_r), 32'(DEPTH)));
          rd_ptr_r <= PW'(wrap_inc(32'(rd_ptr_r), 32'(DEPTH)));
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/latency_credit_buffer.sv
// Issues requests into an external fixed-latency pipe and buffers its returns;
// a credit counter keeps in-flight plus buffered words within the FIFO depth.
module latency_credit_buffer
  import latency_credit_buffer_pkg::*;
#(
  parameter int DW      = 32,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          p_valid,
  output logic [DW-1:0] p_data,
  input  logic          r_valid,
  input  logic [DW-1:0] r_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW:0]   credit_cnt,
  output logic          overflow_err
);

  localparam int CW = AW + 1;

  if (DEPTH < LATENCY + 1) begin : g_depth_check
    $error("latency_credit_buffer: DEPTH must be at least LATENCY+1");
  end

  logic [CW-1:0] credit_r;
  logic          ovf_r;
  logic          fire_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  credit_op_e    cr_op_s;

  assign s_ready      = (credit_r != '0);
  assign fire_s       = s_valid & s_ready;
  assign p_valid      = fire_s;
  assign p_data       = s_data;
  assign m_valid      = ~fifo_empty_s;
  assign pop_s        = m_valid & m_ready;
  assign credit_cnt   = credit_r;
  assign overflow_err = ovf_r;

  // Decode the credit action for this cycle.
  always_comb begin
    cr_op_s = credit_op_e'({pop_s, fire_s});
  end

  // Credit counter; saturates at both bounds as a last line of defence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r <= CW'(DEPTH);
    end else begin
      case (cr_op_s)
        CR_TAKE: begin
          if (credit_r != '0) begin
            credit_r <= credit_r - CW'(1);
          end
        end
        CR_GIVE: begin
          if (credit_r != CW'(DEPTH)) begin
            credit_r <= credit_r + CW'(1);
          end
        end
        default: begin
          credit_r <= credit_r;
        end
      endcase
    end
  end

  // Sticky flag for a return that found no room; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (r_valid & fifo_full_s & ~pop_s);
    end
  end

  lcb_sync_fifo #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (r_valid),
    .wr_data(r_data),
    .rd_en  (pop_s),
    .rd_data(m_data),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  latency_credit_buffer_chk #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .credit_cnt(credit_r),
    .fire      (fire_s),
    .pop       (pop_s)
  );

endmodule
